// File: rtl/credit_flowcontrol.sv
// ----------------------------------------------------------------------------
// credit_flowcontrol
//
// Per-output-port credit tracking for a router output stage. Each port keeps a
// count of free slots in the downstream FIFO. A flit may only be sent to a
// port while that port still holds a credit, and the downstream side returns
// one credit per freed slot. A per-port stall watchdog raises a sticky alarm
// when a port has been requested but starved of credits for STALL_LIMIT
// consecutive cycles.
//
// Optional feature macro: CREDIT_FC_ERR_CHK_EN
//   When defined, err becomes a sticky protocol-violation flag. It is set by
//   a send to an empty port, a credit returned to a full port, or a multi-hot
//   send. When undefined, err is tied low and no check logic is built.
//
// Parameters
//   NPORTS      number of output ports (bit 0=L, 1=N, 2=E, 3=W, 4=S)
//   CREDITS     downstream FIFO depth, 1..15
//   STALL_LIMIT consecutive blocked cycles before the alarm, 1..255
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   port_sel    one-hot port requested by the head flit (0 = no request)
//   send        one-hot, flit transferred to port i this cycle
//   credit_in   one-cycle pulse per freed downstream slot on port i
//   ready_out   port i may accept a flit this cycle
//   credit_cnt  packed credit counters, port i at [i*CW +: CW]
//   port_idle   port i holds all of its credits
//   stall_alarm sticky per-port starvation flag
//   err         sticky protocol-violation flag (see macro above)
// ----------------------------------------------------------------------------
module credit_flowcontrol #(
    parameter int NPORTS      = 5,
    parameter int CREDITS     = 4,
    parameter int STALL_LIMIT = 64,
    localparam int CW         = $clog2(CREDITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS-1:0]    port_sel,
    input  logic [NPORTS-1:0]    send,
    input  logic [NPORTS-1:0]    credit_in,
    output logic [NPORTS-1:0]    ready_out,
    output logic [NPORTS*CW-1:0] credit_cnt,
    output logic [NPORTS-1:0]    port_idle,
    output logic [NPORTS-1:0]    stall_alarm,
    output logic                 err
);

    localparam logic [CW-1:0] CREDITS_W = CW'(CREDITS);
    localparam logic [CW-1:0] ONE_W     = CW'(1);
    localparam logic [7:0]    LIMIT_W   = 8'(STALL_LIMIT);
    localparam logic [7:0]    LIMIT_M1  = 8'(STALL_LIMIT - 1);

    logic [CW-1:0]     cnt   [NPORTS];
    logic [7:0]        stall [NPORTS];
    logic [NPORTS-1:0] blocked;

    // A port is blocked when its head flit wants it but no credit is left.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < NPORTS; i++) begin
            blocked[i] = port_sel[i] && (cnt[i] == '0);
        end
    end

    // Credit counters and stall watchdogs. A simultaneous send and credit
    // return cancel out, and both directions saturate instead of wrapping.
    // The alarm is raised on the same edge the stall counter hits the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPORTS; i++) begin
                cnt[i]   <= CREDITS_W;
                stall[i] <= '0;
            end
            stall_alarm <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (send[i] && !credit_in[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - ONE_W;
                end else if (credit_in[i] && !send[i] && (cnt[i] < CREDITS_W)) begin
                    cnt[i] <= cnt[i] + ONE_W;
                end

                if (blocked[i]) begin
                    if (stall[i] != LIMIT_W) begin
                        stall[i] <= stall[i] + 8'd1;
                    end
                    if (stall[i] == LIMIT_M1) begin
                        stall_alarm[i] <= 1'b1;
                    end
                end else begin
                    stall[i] <= '0;
                end
            end
        end
    end

    // ready_out looks only at the registered count, never at send, so it is
    // safe to use when deciding whether to send. It is held low during reset.
    genvar g;
    generate
        for (g = 0; g < NPORTS; g++) begin : g_port
            assign ready_out[g]              = !rst && port_sel[g] && (cnt[g] != '0);
            assign port_idle[g]              = (cnt[g] == CREDITS_W);
            assign credit_cnt[g*CW +: CW]    = cnt[g];
        end
    endgenerate

`ifdef CREDIT_FC_ERR_CHK_EN
    logic violation;

    // A send paired with a same-cycle credit return on the same port is a
    // legal swap and is not flagged, even at the counter limits.
    always_comb begin
        violation = ($countones(send) > 1);
        for (int i = 0; i < NPORTS; i++) begin
            if (send[i] && !credit_in[i] && (cnt[i] == '0)) begin
                violation = 1'b1;
            end
            if (credit_in[i] && !send[i] && (cnt[i] == CREDITS_W)) begin
                violation = 1'b1;
            end
        end
    end

    // Sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (violation) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_credit_flowcontrol.sv
// ----------------------------------------------------------------------------
// tb_credit_flowcontrol
//
// Testbench for credit_flowcontrol with default parameters (5 ports,
// 4 credits, stall limit 64). Directed scenarios walk through draining,
// credit return latency, cancelling send/credit pairs, the stall alarm, the
// empty-port send and mid-traffic reset, followed by a randomized phase.
// Expected values come from a per-port arithmetic model of credits, stall
// run lengths and sticky flags.
// ----------------------------------------------------------------------------
module tb_credit_flowcontrol;

    localparam int NPORTS      = 5;
    localparam int CREDITS     = 4;
    localparam int STALL_LIMIT = 64;
    localparam int CW          = $clog2(CREDITS + 1);

    logic                 clk;
    logic                 rst;
    logic [NPORTS-1:0]    port_sel;
    logic [NPORTS-1:0]    send;
    logic [NPORTS-1:0]    credit_in;
    logic [NPORTS-1:0]    ready_out;
    logic [NPORTS*CW-1:0] credit_cnt;
    logic [NPORTS-1:0]    port_idle;
    logic [NPORTS-1:0]    stall_alarm;
    logic                 err;

    int total = 0;
    int bad   = 0;

    // Reference state: free slots, current blocked-run length, sticky flags.
    int                m_cnt   [NPORTS];
    int                m_run   [NPORTS];
    logic [NPORTS-1:0] m_alarm;
    logic              m_err;

    credit_flowcontrol #(
        .NPORTS      (NPORTS),
        .CREDITS     (CREDITS),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .port_sel    (port_sel),
        .send        (send),
        .credit_in   (credit_in),
        .ready_out   (ready_out),
        .credit_cnt  (credit_cnt),
        .port_idle   (port_idle),
        .stall_alarm (stall_alarm),
        .err         (err)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and counts/reports a failure.
    task automatic check_val(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int i);
        return credit_cnt[i*CW +: CW];
    endfunction

    // Advance the reference by one clock edge using the sampled inputs.
    task automatic model_update(input logic [NPORTS-1:0] sel, snd, cin,
                                input logic r);
        if (r) begin
            for (int i = 0; i < NPORTS; i++) begin
                m_cnt[i] = CREDITS;
                m_run[i] = 0;
            end
            m_alarm = '0;
            m_err   = 1'b0;
        end else begin
`ifdef CREDIT_FC_ERR_CHK_EN
            if ($countones(snd) > 1) m_err = 1'b1;
            for (int i = 0; i < NPORTS; i++) begin
                if (snd[i] && !cin[i] && m_cnt[i] == 0) m_err = 1'b1;
                if (cin[i] && !snd[i] && m_cnt[i] == CREDITS) m_err = 1'b1;
            end
`endif
            for (int i = 0; i < NPORTS; i++) begin
                if (sel[i] && m_cnt[i] == 0) begin
                    m_run[i] = (m_run[i] + 1 > STALL_LIMIT) ? STALL_LIMIT : m_run[i] + 1;
                    if (m_run[i] == STALL_LIMIT) m_alarm[i] = 1'b1;
                end else begin
                    m_run[i] = 0;
                end
                if (snd[i] && !cin[i] && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                else if (cin[i] && !snd[i] && m_cnt[i] < CREDITS) m_cnt[i] = m_cnt[i] + 1;
            end
        end
    endtask

    // Compare registered outputs against the reference.
    task automatic check_output();
        logic [NPORTS*CW-1:0] exp_cnt;
        logic [NPORTS-1:0]    exp_idle;
        for (int i = 0; i < NPORTS; i++) begin
            exp_cnt[i*CW +: CW] = CW'(m_cnt[i]);
            exp_idle[i]         = (m_cnt[i] == CREDITS);
        end
        check_val("credit_cnt", 32'(credit_cnt), 32'(exp_cnt));
        check_val("port_idle", 32'(port_idle), 32'(exp_idle));
        check_val("stall_alarm", 32'(stall_alarm), 32'(m_alarm));
        check_val("err", 32'(err), 32'(m_err));
    endtask

    // Drive one cycle: check combinational ready mid-cycle, then the
    // registered outputs just after the edge.
    task automatic apply_stimulus(input logic [NPORTS-1:0] sel, snd, cin,
                                  input logic r);
        logic [NPORTS-1:0] exp_ready;
        port_sel  = sel;
        send      = snd;
        credit_in = cin;
        rst       = r;
        #1;
        for (int i = 0; i < NPORTS; i++) begin
            exp_ready[i] = !r && sel[i] && (m_cnt[i] != 0);
        end
        check_val("ready_out", 32'(ready_out), 32'(exp_ready));
        @(posedge clk);
        model_update(sel, snd, cin, r);
        #1;
        check_output();
    endtask

    initial begin
        logic [NPORTS-1:0] rsel, rsnd, rcin;
        logic              rr;

        for (int i = 0; i < NPORTS; i++) begin
            m_cnt[i] = CREDITS;
            m_run[i] = 0;
        end
        m_alarm   = '0;
        m_err     = 1'b0;
        port_sel  = '0;
        send      = '0;
        credit_in = '0;
        rst       = 1'b1;

        $display("[TB] reset");
        apply_stimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
        apply_stimulus(5'b11111, 5'b00001, 5'b00010, 1'b1);
        check_val("reset_idle", 32'(port_idle), 32'h1f);
        check_val("reset_err", 32'(err), 32'h0);

        $display("[TB] drain port 1");
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(5'b00010, 5'b00010, 5'b00000, 1'b0);
            check_val("drain_cnt1", 32'(cnt_of(1)), 32'(3 - k));
        end
        apply_stimulus(5'b00010, 5'b00000, 5'b00000, 1'b0);
        check_val("drain_ready1", 32'(ready_out[1]), 32'h0);

        $display("[TB] credit return latency on port 2");
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(5'b00100, 5'b00100, 5'b00000, 1'b0);
        end
        apply_stimulus(5'b00100, 5'b00000, 5'b00100, 1'b0);
        port_sel = 5'b00100;
        send     = '0;
        credit_in = '0;
        #1;
        check_val("return_ready2", 32'(ready_out[2]), 32'h1);
        check_val("return_cnt2", 32'(cnt_of(2)), 32'h1);

        $display("[TB] send and credit together on port 3");
        apply_stimulus(5'b01000, 5'b01000, 5'b01000, 1'b0);
        check_val("both_at4", 32'(cnt_of(3)), 32'h4);
        apply_stimulus(5'b01000, 5'b01000, 5'b00000, 1'b0);
        apply_stimulus(5'b01000, 5'b01000, 5'b00000, 1'b0);
        apply_stimulus(5'b01000, 5'b01000, 5'b01000, 1'b0);
        check_val("both_at2", 32'(cnt_of(3)), 32'h2);
        apply_stimulus(5'b01000, 5'b01000, 5'b00000, 1'b0);
        apply_stimulus(5'b01000, 5'b01000, 5'b00000, 1'b0);
        apply_stimulus(5'b01000, 5'b01000, 5'b01000, 1'b0);
        check_val("both_at0", 32'(cnt_of(3)), 32'h0);
        check_val("both_err", 32'(err), 32'h0);

        $display("[TB] stall alarm on port 0");
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(5'b00001, 5'b00001, 5'b00000, 1'b0);
        end
        for (int k = 0; k < STALL_LIMIT - 1; k++) begin
            apply_stimulus(5'b00001, 5'b00000, 5'b00000, 1'b0);
        end
        check_val("alarm_before", 32'(stall_alarm[0]), 32'h0);
        apply_stimulus(5'b00001, 5'b00000, 5'b00000, 1'b0);
        check_val("alarm_at_limit", 32'(stall_alarm[0]), 32'h1);
        apply_stimulus(5'b00001, 5'b00000, 5'b00001, 1'b0);
        apply_stimulus(5'b00001, 5'b00000, 5'b00000, 1'b0);
        check_val("alarm_sticky", 32'(stall_alarm[0]), 32'h1);

        $display("[TB] send to empty port 4");
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(5'b10000, 5'b10000, 5'b00000, 1'b0);
        end
        apply_stimulus(5'b10000, 5'b10000, 5'b00000, 1'b0);
        check_val("empty_cnt4", 32'(cnt_of(4)), 32'h0);
`ifdef CREDIT_FC_ERR_CHK_EN
        check_val("empty_err", 32'(err), 32'h1);
`else
        check_val("empty_err", 32'(err), 32'h0);
`endif

        $display("[TB] reset mid-traffic");
        apply_stimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
        for (int p = 0; p < NPORTS; p++) begin
            for (int k = 0; k < 3; k++) begin
                apply_stimulus(NPORTS'(1) << p, NPORTS'(1) << p, 5'b00000, 1'b0);
            end
        end
        check_val("pre_reset_cnt", 32'(credit_cnt), 32'h1249);
        apply_stimulus(5'b11111, 5'b00100, 5'b01000, 1'b1);
        check_val("mid_reset_cnt", 32'(credit_cnt), 32'h4924);
        check_val("mid_reset_idle", 32'(port_idle), 32'h1f);
        check_val("mid_reset_alarm", 32'(stall_alarm), 32'h0);
        check_val("mid_reset_err", 32'(err), 32'h0);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 600; k++) begin
            rsel = NPORTS'($urandom);
            rsnd = NPORTS'($urandom) & NPORTS'($urandom) & NPORTS'($urandom);
            rcin = NPORTS'($urandom) & NPORTS'($urandom);
            rr   = ($urandom_range(0, 79) == 0);
            apply_stimulus(rsel, rsnd, rcin, rr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/credit_flowcontrol.md
CREDIT_FLOWCONTROL -- requirements
Module: credit_flowcontrol

Interface
REQ-001 SHALL have parameter NPORTS, default 5, number of output ports (bit 0=L, 1=N, 2=E, 3=W, 4=S).
REQ-002 SHALL have parameter CREDITS, default 4, downstream FIFO depth; legal range 1..15.
REQ-003 SHALL have parameter STALL_LIMIT, default 64, consecutive blocked cycles before the stall alarm; legal range 1..255.
REQ-004 SHALL derive localparam CW = $clog2(CREDITS+1), the credit counter width.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port port_sel, input, NPORTS, one-hot output port requested by the head flit; all-zero = no request.
REQ-008 SHALL have port send, input, NPORTS, one-hot, flit transferred to port i this cycle.
REQ-009 SHALL have port credit_in, input, NPORTS, one-cycle pulse per freed downstream slot on port i.
REQ-010 SHALL have port ready_out, output, NPORTS, port i may accept a flit this cycle.
REQ-011 SHALL have port credit_cnt, output, NPORTS*CW, packed counters; port i at [i*CW +: CW].
REQ-012 SHALL have port port_idle, output, NPORTS, credit_cnt[i]==CREDITS.
REQ-013 SHALL have port stall_alarm, output, NPORTS, sticky per-port starvation flag.
REQ-014 SHALL have port err, output, 1, sticky protocol-violation flag (see Configuration).

Function
REQ-015 SHALL keep one CW-bit credit counter per port, updated on the rising clk edge only.
REQ-016 SHALL drive ready_out[i] = port_sel[i] && (credit_cnt[i] != 0), combinationally from the registered counter, with no dependency on send.
REQ-017 SHALL decrement counter i by 1 when send[i]=1 and credit_in[i]=0 and the counter is nonzero.
REQ-018 SHALL increment counter i by 1 when credit_in[i]=1 and send[i]=0 and the counter is below CREDITS.
REQ-019 SHALL leave counter i unchanged when send[i] and credit_in[i] are both 1, including at 0 and at CREDITS.
REQ-020 SHALL ignore send[i] at counter 0 (no wrap to all-ones) and credit_in[i] at counter CREDITS (saturate).
REQ-021 SHALL make a credit returned in cycle t visible on ready_out in cycle t+1 (one-cycle credit latency).
REQ-022 SHALL keep one 8-bit stall counter per port that increments each cycle port_sel[i]=1 and credit_cnt[i]=0, and clears on any cycle where that condition is false.
REQ-023 SHALL set stall_alarm[i] on the cycle the stall counter reaches STALL_LIMIT, and hold it until rst; the stall counter SHALL saturate at STALL_LIMIT.
REQ-024 SHALL treat each port independently; multi-hot port_sel SHALL be evaluated per bit without error.

Reset
REQ-025 SHALL load every credit counter with CREDITS on rst=1 at a clock edge.
REQ-026 SHALL clear all stall counters, stall_alarm and err on rst.
REQ-027 SHALL force ready_out to all-zero while rst=1, so that port_idle is all-ones and credit_cnt equals CREDITS on each port one cycle after rst is sampled.
REQ-028 SHALL discard send and credit_in sampled in any cycle where rst=1, including mid-operation.

Configuration
REQ-029 SHALL define macro CREDIT_FC_ERR_CHK_EN: when defined, err SHALL set on the next edge after any send[i] at counter 0, credit_in[i] at counter CREDITS (without same-cycle send[i]), or send with popcount > 1.
REQ-030 SHALL, without CREDIT_FC_ERR_CHK_EN, tie err to constant 0 with no check logic; counter saturation SHALL be identical in both builds.

Verification
REQ-031 SHALL cover: reset, then port_sel=00010, send[1] for 4 consecutive cycles with CREDITS=4 -> credit_cnt[1] goes 3,2,1,0; ready_out[1]=0 in cycle 5.
REQ-032 SHALL cover: counter 0 on port 2, credit_in[2] pulse in cycle t -> ready_out[2]=1 in cycle t+1 with credit_cnt[2]=1.
REQ-033 SHALL cover: send[3] and credit_in[3] together at counters 0, 2 and 4 -> counter unchanged each time; err stays 0.
REQ-034 SHALL cover: port_sel[0]=1 at counter 0 for 64 cycles with STALL_LIMIT=64 -> stall_alarm[0]=1 after the 64th blocked edge; still 1 after a credit returns.
REQ-035 SHALL cover: with CREDIT_FC_ERR_CHK_EN, send[4] at counter 0 -> err=1 next cycle and credit_cnt[4] stays 0; without the macro -> err=0.
REQ-036 SHALL cover: rst asserted mid-traffic with counters at 1 -> all counters 4, port_idle=11111, stall_alarm=0 and err=0 one cycle later.
